neander_mem_responder: RTL

- Memory-side responder for the Neander-style CPU. It serves the CPU's memory read/write requests over a req/ack handshake with programmable wait states.
- Holds a 256x8 storage array. 0x00-0x7F is the program region; 0x80-0xFF is the data region.
- Mirrors the data byte at OUT_ADDR onto a registered output port that drives the seven-segment displays.
- A load-mode input allows a boot loader to write the program region; in run mode that region is read-only.

---
 rtl/neander_pkg.sv | 31 +++
 rtl/neander_wait_counter.sv | 40 ++++
 rtl/neander_mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/neander_pkg.sv
// Shared definitions for the Neander memory responder.
// Holds the FSM state encoding, address-map constants and small helpers.
// Pure declarations: no logic, no latency, no flow control.
package neander_pkg;

    // Responder transaction states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    // Address map: program region 0x00-0x7F, data region 0x80-0xFF
    localparam logic [7:0] PROG_LAST        = 8'h7F;
    localparam logic [7:0] DATA_BASE        = 8'h80;
    localparam logic [7:0] DEFAULT_OUT_ADDR = 8'h80;

    // Width of the wait-state counter (WAIT_CYCLES is 0..7)
    localparam int CNT_W = 3;

    // True for addresses that are always writable
    function automatic logic is_data_addr(input logic [7:0] a);
        return (a >= DATA_BASE);
    endfunction

    // True for addresses in the load-mode-protected region
    function automatic logic is_prog_addr(input logic [7:0] a);
        return (a <= PROG_LAST);
    endfunction

endpackage

// File: rtl/neander_wait_counter.sv
// Loadable 3-bit down-counter with a terminal-count flag (count == 1).
// Latency: load/decrement take effect on the next rising edge.
// No backpressure: load has priority over decrement.
module neander_wait_counter
    import neander_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on a new transaction, otherwise step down while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last wait cycle: the FSM moves to ACK on the next edge
    assign tc_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/neander_mem_responder.sv
// Memory-side responder: 256x8 store, req/ack handshake, out_port mirror.
// Latency: ack is high WAIT_CYCLES cycles after the accepting edge, for one cycle.
// Backpressure: busy from acceptance through ACK; req is ignored outside IDLE.
module neander_mem_responder
    import neander_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  OUT_ADDR    = DEFAULT_OUT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       load_en,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       wr_err,
    output logic [7:0] out_port
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_e     state_q, state_d;

    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       load_en_q, load_en_d;

    logic [7:0] rdata_q, rdata_d;
    logic [7:0] out_q, out_d;
    logic       wr_err_q, wr_err_d;

    logic       accept;
    logic       enter_ack;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_tc;

    // Request fields in effect on the ACK-entry edge. With zero wait states
    // that edge is also the accepting edge, so the live inputs are used.
    logic       cur_we;
    logic [7:0] cur_addr;
    logic [7:0] cur_wdata;
    logic       cur_load_en;
    logic       wr_ok;
    logic       do_write;

    logic [7:0] mem [0:255];

    neander_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LD),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // FSM next state: accept in IDLE, count down in WAIT, single-cycle ACK
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        enter_ack = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_LD == '0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_tc) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Select live or latched request fields and decide the access outcome
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we      = we;
            cur_addr    = addr;
            cur_wdata   = wdata;
            cur_load_en = load_en;
        end else begin
            cur_we      = we_q;
            cur_addr    = addr_q;
            cur_wdata   = wdata_q;
            cur_load_en = load_en_q;
        end
        wr_ok    = is_data_addr(cur_addr) || cur_load_en;
        do_write = enter_ack && cur_we && wr_ok;
    end

    // Next values of the request latch and the registered outputs
    always_comb begin
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_en_d = load_en_q;
        rdata_d   = rdata_q;
        out_d     = out_q;
        wr_err_d  = 1'b0;
        if (accept) begin
            we_d      = we;
            addr_d    = addr;
            wdata_d   = wdata;
            load_en_d = load_en;
        end
        if (enter_ack && !cur_we) begin
            rdata_d = mem[cur_addr];
        end
        if (do_write && (cur_addr == OUT_ADDR)) begin
            out_d = cur_wdata;
        end
        if (enter_ack && cur_we && is_prog_addr(cur_addr) && !cur_load_en) begin
            wr_err_d = 1'b1;
        end
    end

    // State, request latch and output registers; reset aborts any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            load_en_q <= 1'b0;
            rdata_q   <= 8'h00;
            out_q     <= 8'h00;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            load_en_q <= load_en_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Storage array: written only on the ACK-entry edge, never cleared by reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[cur_addr] <= cur_wdata;
        end
    end

    assign ack      = (state_q == ST_ACK);
    assign busy     = (state_q != ST_IDLE);
    assign rdata    = rdata_q;
    assign wr_err   = wr_err_q;
    assign out_port = out_q;

endmodule
